uart_stream_rx: RTL and testbench
=================================

UART_STREAM_RX -- requirements
Module: uart_stream_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 16000000, meaning i_clk frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, meaning line bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD, truncated, and SHALL be at least 4.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning output FIFO entries; SHALL be a power of two.
REQ-004 SHALL have parameter EOL, default 8'h0A, meaning the byte value that marks the last byte of a frame.
REQ-005 SHALL have port i_clk, input, 1 bit: the single clock.
REQ-006 SHALL have port i_rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port i_uart_rx, input, 1 bit: asynchronous serial line, idle high.
REQ-008 SHALL have port o_tdata, output, 8 bits: stream byte.
REQ-009 SHALL have port o_tlast, output, 1 bit: the current byte equals EOL.
REQ-010 SHALL have port o_tvalid, output, 1 bit: the FIFO is non-empty.
REQ-011 SHALL have port i_tready, input, 1 bit: sink accepts the byte.
REQ-012 SHALL have port o_frame_err, output, 1 bit: one-cycle pulse when a stop bit is sampled low.
REQ-013 SHALL have port o_overrun, output, 1 bit: one-cycle pulse when a received byte is dropped because the FIFO is full.

Function
REQ-014 SHALL pass i_uart_rx through a 2-flop synchronizer (reset value 1) before any use.
REQ-015 SHALL implement the FSM states IDLE, START, DATA, STOP and WAIT_HIGH.
REQ-016 In IDLE, SHALL go to START on synchronized rx = 0 and load the bit counter with CLKS_PER_BIT/2-1.
REQ-017 In START, at counter zero, SHALL go to DATA if rx = 0; otherwise it SHALL treat the event as a glitch and return to IDLE with no output.
REQ-018 In DATA, SHALL sample rx every CLKS_PER_BIT cycles (bit centre), 8 bits LSB first, then go to STOP.
REQ-019 In STOP, at bit centre, if rx = 1 SHALL push the byte and go to IDLE in the same cycle, so that the next start edge is detectable immediately.
REQ-020 In STOP, at bit centre, if rx = 0 SHALL pulse o_frame_err, discard the byte and go to WAIT_HIGH.
REQ-021 In WAIT_HIGH, SHALL stay until rx = 1, then go to IDLE; a held break produces exactly one o_frame_err.
REQ-022 SHALL store tlast in the FIFO alongside each byte, set when byte == EOL.
REQ-023 SHALL make a pushed byte visible on o_tvalid/o_tdata on the cycle after the stop-bit centre sample.
REQ-024 Handshake: SHALL pop the FIFO on o_tvalid & i_tready; o_tdata/o_tlast SHALL hold stable while o_tvalid & !i_tready.
REQ-025 Push to a full FIFO with no pop in the same cycle SHALL drop the new byte (stored data is kept) and pulse o_overrun.
REQ-026 Push and pop in the same cycle when full SHALL accept the push with no overrun; when empty, the push SHALL succeed and the pop SHALL not occur (o_tvalid was low).
REQ-027 FIFO pointers SHALL wrap modulo FIFO_DEPTH; the occupancy count SHALL be log2(FIFO_DEPTH)+1 bits.
REQ-028 The sink SHALL never stall the receive FSM.

Reset
REQ-029 While i_rst_n = 0, SHALL hold FSM = IDLE, counters = 0, FIFO empty, synchronizer = 1, o_tvalid = 0, o_tlast = 0, o_tdata = 0, o_frame_err = 0, o_overrun = 0.
REQ-030 Reset asserted mid-byte SHALL discard the partial byte and all FIFO contents.
REQ-031 After deassertion, a line already low SHALL be treated as a start bit.

Structure
REQ-032 The FSM state encodings and the CLKS_PER_BIT derivation SHALL live in shared package observer_pkg.
REQ-033 The FIFO SHALL be sub-module uart_rx_fifo (8+1 bits wide, parameter FIFO_DEPTH); the FSM and synchronizer SHALL stay in uart_stream_rx.

Verification (CLK_FREQ=1000000, BAUD=100000, i.e. 10 clocks per bit)
REQ-034 SHALL cover: frame 0x55 with i_tready = 1 -> one beat, tdata = 0x55, tlast = 0, valid 1 cycle after the stop centre.
REQ-035 SHALL cover: bytes "O","K",0x0A back-to-back -> three beats, tlast = 1 only on 0x0A.
REQ-036 SHALL cover: i_tready = 0 and 5 bytes sent -> first 4 held in order, 1 o_overrun pulse, 5th byte absent.
REQ-037 SHALL cover: 0x41 sent with the stop bit forced low, then the line released -> 1 o_frame_err, no beat, next byte 0x42 received correctly.
REQ-038 SHALL cover: a 3-cycle low glitch on an idle line -> no beat, no error.
REQ-039 SHALL cover: i_rst_n pulsed low during DATA bit 4 -> outputs at reset values, next full byte 0xA5 received correctly.

Source files
------------

// File: rtl/observer_pkg.sv
// -----------------------------------------------------------------------------
// observer_pkg
// Shared definitions for the UART stream receiver:
//   - rx_state_t   : receive FSM state encoding
//   - rx_beat_t    : one FIFO entry (tlast flag + data byte)
//   - clks_per_bit : clock cycles per line bit, CLK_FREQ/BAUD truncated
// -----------------------------------------------------------------------------
package observer_pkg;

   localparam int DATA_BITS = 8;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_DATA      = 3'd2,
      ST_STOP      = 3'd3,
      ST_WAIT_HIGH = 3'd4
   } rx_state_t;

   typedef struct packed {
      logic                 last;
      logic [DATA_BITS-1:0] data;
   } rx_beat_t;

   // Integer division truncates; callers must keep the result >= 4 so the
   // half-bit reload (cpb/2 - 1) stays at least 1.
   function automatic int clks_per_bit(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

endpackage : observer_pkg

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// Small synchronous FIFO holding received beats (8 data bits + tlast).
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset (flushes contents)
//   i_push, i_wdata: write request and beat
//   i_pop          : read request; only honoured while the FIFO is non-empty
//   o_rdata        : head beat, forced to zero while empty
//   o_valid        : FIFO non-empty
//   o_overrun      : one-cycle pulse when a push is dropped (full, no pop)
// FIFO_DEPTH must be a power of two.
// -----------------------------------------------------------------------------
module uart_rx_fifo
   import observer_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic     i_clk,
   input  logic     i_rst_n,
   input  logic     i_push,
   input  rx_beat_t i_wdata,
   input  logic     i_pop,
   output rx_beat_t o_rdata,
   output logic     o_valid,
   output logic     o_overrun
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   rx_beat_t        mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CW-1:0]   count;
   logic            empty;
   logic            full;
   logic            do_push;
   logic            do_pop;

   function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
      return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty   = (count == '0);
   assign full    = (count == CW'(FIFO_DEPTH));
   // A pop only happens when there is something to pop, so a push into an
   // empty FIFO never races with a pop. When full, a same-cycle pop frees
   // the slot the push needs.
   assign do_pop  = i_pop & ~empty;
   assign do_push = i_push & (~full | do_pop);

   assign o_overrun = i_push & full & ~do_pop;
   assign o_valid   = ~empty;
   assign o_rdata   = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge i_clk) begin
      if (do_push) begin
         mem[wr_ptr] <= i_wdata;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= next_ptr(wr_ptr);
         end
         if (do_pop) begin
            rd_ptr <= next_ptr(rd_ptr);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule : uart_rx_fifo

// File: rtl/uart_stream_rx.sv
// -----------------------------------------------------------------------------
// uart_stream_rx
// 8N1 UART receiver feeding a valid/ready byte stream through a small FIFO.
// Parameters:
//   CLK_FREQ   : i_clk frequency in Hz
//   BAUD       : line bit rate (CLK_FREQ/BAUD must be >= 4)
//   FIFO_DEPTH : output FIFO entries (power of two)
//   EOL        : byte value flagged with o_tlast
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_uart_rx      : asynchronous serial input, idle high
//   o_tdata/o_tlast/o_tvalid, i_tready : output byte stream
//   o_frame_err    : one-cycle pulse when a stop bit is sampled low
//   o_overrun      : one-cycle pulse when a byte is dropped on a full FIFO
//
// Stream handshake: a beat transfers on every cycle where o_tvalid & i_tready
// are both high. o_tvalid never depends on i_tready, and while o_tvalid is
// high without i_tready, o_tdata/o_tlast hold their value. The sink never
// back-pressures the receiver; a full FIFO drops bytes instead.
//
// The FSM state is held in `state` (type rx_state_t) for observation.
// -----------------------------------------------------------------------------
module uart_stream_rx
   import observer_pkg::*;
#(
   parameter int         CLK_FREQ   = 16000000,
   parameter int         BAUD       = 115200,
   parameter int         FIFO_DEPTH = 4,
   parameter logic [7:0] EOL        = 8'h0A
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_uart_rx,
   output logic [7:0] o_tdata,
   output logic       o_tlast,
   output logic       o_tvalid,
   input  logic       i_tready,
   output logic       o_frame_err,
   output logic       o_overrun
);

   localparam int CPB   = clks_per_bit(CLK_FREQ, BAUD);
   localparam int CNT_W = $clog2(CPB);
   localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(CPB / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_RELOAD = CNT_W'(CPB - 1);

   rx_state_t         state;
   rx_state_t         next_state;
   logic              rx_meta;
   logic              rx_sync;
   logic [CNT_W-1:0]  bit_cnt;
   logic [2:0]        bit_idx;
   logic [7:0]        shreg;
   logic              cnt_zero;
   logic              push_byte;
   logic              stop_centre;
   rx_beat_t          wr_beat;
   rx_beat_t          rd_beat;

   // Two-flop synchronizer; resets to the idle (high) line level.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_meta <= i_uart_rx;
         rx_sync <= rx_meta;
      end
   end

   assign cnt_zero = (bit_cnt == '0);

   // State register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic.
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: begin
            if (!rx_sync) next_state = ST_START;
         end
         ST_START: begin
            // Line must still be low half a bit after the edge, otherwise
            // it was a glitch and nothing is reported.
            if (cnt_zero) next_state = rx_sync ? ST_IDLE : ST_DATA;
         end
         ST_DATA: begin
            if (cnt_zero && (bit_idx == 3'd7)) next_state = ST_STOP;
         end
         ST_STOP: begin
            // Valid stop returns straight to IDLE so a start bit that
            // follows immediately is still caught.
            if (cnt_zero) next_state = rx_sync ? ST_IDLE : ST_WAIT_HIGH;
         end
         ST_WAIT_HIGH: begin
            // A held break stays here, so it raises only one frame error.
            if (rx_sync) next_state = ST_IDLE;
         end
         default: next_state = ST_IDLE;
      endcase
   end

   // Output logic: decisions taken at the stop-bit centre.
   always_comb begin
      stop_centre = 1'b0;
      push_byte   = 1'b0;
      o_frame_err = 1'b0;
      if (state == ST_STOP && cnt_zero) begin
         stop_centre = 1'b1;
         push_byte   = rx_sync;
         o_frame_err = ~rx_sync;
      end
   end

   // Bit timing counter, bit index and shift register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         bit_cnt <= '0;
         bit_idx <= '0;
         shreg   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               // Half-bit reload places later samples at bit centres.
               if (!rx_sync) bit_cnt <= HALF_RELOAD;
            end
            ST_START: begin
               if (cnt_zero) begin
                  bit_cnt <= FULL_RELOAD;
                  bit_idx <= '0;
               end else begin
                  bit_cnt <= bit_cnt - 1'b1;
               end
            end
            ST_DATA: begin
               if (cnt_zero) begin
                  // LSB first: new bits enter at the top and shift down.
                  shreg   <= {rx_sync, shreg[7:1]};
                  bit_cnt <= FULL_RELOAD;
                  bit_idx <= bit_idx + 1'b1;
               end else begin
                  bit_cnt <= bit_cnt - 1'b1;
               end
            end
            ST_STOP: begin
               if (!stop_centre) bit_cnt <= bit_cnt - 1'b1;
            end
            default: begin
               bit_cnt <= bit_cnt;
            end
         endcase
      end
   end

   assign wr_beat.data = shreg;
   assign wr_beat.last = (shreg == EOL);

   uart_rx_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_push    (push_byte),
      .i_wdata   (wr_beat),
      .i_pop     (i_tready),
      .o_rdata   (rd_beat),
      .o_valid   (o_tvalid),
      .o_overrun (o_overrun)
   );

   assign o_tdata = rd_beat.data;
   assign o_tlast = rd_beat.last;

endmodule : uart_stream_rx

// File: tb/tb_uart_stream_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_stream_rx
// Bench for uart_stream_rx at 10 clocks per bit. Bytes are serialised by a
// driver task; a negedge monitor scores every accepted beat against a queue
// of expected bytes, checks hold-stability under back-pressure and counts
// o_frame_err / o_overrun pulses.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_stream_rx;

   localparam int         CLK_FREQ = 1000000;
   localparam int         BAUD     = 100000;
   localparam int         CPB      = CLK_FREQ / BAUD;
   localparam int         DEPTH    = 4;
   localparam logic [7:0] EOL      = 8'h0A;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       uart_rx = 1'b1;
   logic       tready = 1'b1;
   logic [7:0] tdata;
   logic       tlast;
   logic       tvalid;
   logic       frame_err;
   logic       overrun;

   always #5 clk = ~clk;

   uart_stream_rx #(
      .CLK_FREQ   (CLK_FREQ),
      .BAUD       (BAUD),
      .FIFO_DEPTH (DEPTH),
      .EOL        (EOL)
   ) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_uart_rx   (uart_rx),
      .o_tdata     (tdata),
      .o_tlast     (tlast),
      .o_tvalid    (tvalid),
      .i_tready    (tready),
      .o_frame_err (frame_err),
      .o_overrun   (overrun)
   );

   // ---------------- scoreboard state ----------------
   int         n_vec = 0;
   int         n_err = 0;
   int         cyc = 0;
   logic [7:0] exp_q[$];
   int         beats = 0;
   int         last_beats = 0;
   int         fe_cnt = 0;
   int         ovr_cnt = 0;
   int         run_len = 0;
   int         last_run = 0;
   int         rise_cyc = 0;
   bit         rand_ready = 1'b0;
   bit         hold_valid = 1'b0;
   logic [8:0] hold_val = '0;

   always @(posedge clk) cyc <= cyc + 1;

   // Random sink back-pressure when enabled.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_ready) tready = 1'($urandom_range(0, 1));
      end
   end

   // Monitor / scoreboard.
   initial begin
      logic [7:0] e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            run_len    = 0;
            hold_valid = 1'b0;
         end else begin
            if (frame_err) fe_cnt++;
            if (overrun) ovr_cnt++;
            if (tvalid) begin
               run_len++;
               if (run_len == 1) rise_cyc = cyc;
            end else if (run_len > 0) begin
               last_run = run_len;
               run_len  = 0;
            end
            if (hold_valid) begin
               n_vec++;
               if (!tvalid || {tlast, tdata} !== hold_val) begin
                  n_err++;
                  $display("FAIL hold_stable: got valid=%b last/data=%h, required valid=1 last/data=%h",
                           tvalid, {tlast, tdata}, hold_val);
               end
            end
            hold_valid = tvalid && !tready;
            hold_val   = {tlast, tdata};
            if (tvalid && tready) begin
               n_vec++;
               beats++;
               if (tlast) last_beats++;
               if (exp_q.size() == 0) begin
                  n_err++;
                  $display("FAIL beat: got unexpected data=%h last=%b, required no beat", tdata, tlast);
               end else begin
                  e = exp_q.pop_front();
                  if ({tlast, tdata} !== {e == EOL, e}) begin
                     n_err++;
                     $display("FAIL beat: got data=%h last=%b, required data=%h last=%b",
                              tdata, tlast, e, e == EOL);
                  end
               end
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Serialise one 8N1 frame; the line is left at the stop level.
   task automatic send_byte(input logic [7:0] b, input logic stop_val);
      uart_rx = 1'b0;
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         tick(CPB);
      end
      uart_rx = stop_val;
      tick(CPB);
   endtask

   task automatic wait_drain(input int budget);
      bit done;
      done = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (exp_q.size() == 0 && !tvalid) begin
            done = 1'b1;
            break;
         end
         tick(1);
      end
      n_vec++;
      if (!done) begin
         n_err++;
         $display("FAIL drain_timeout: got %0d bytes pending, required 0 within %0d cycles",
                  exp_q.size(), budget);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      n_vec++;
      if ({tvalid, tlast, tdata, frame_err, overrun} !== 12'h000) begin
         n_err++;
         $display("FAIL %s: got valid=%b last=%b data=%h ferr=%b ovr=%b, required all zero",
                  tag, tvalid, tlast, tdata, frame_err, overrun);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      tick(4);
      check_reset_outputs("reset_hold");
      rst_n = 1'b1;
      tick(20);
      n_vec++;
      if (tvalid !== 1'b0 || fe_cnt != 0 || ovr_cnt != 0) begin
         n_err++;
         $display("FAIL reset_idle: got valid=%b ferr=%0d ovr=%0d, required 0/0/0", tvalid, fe_cnt, ovr_cnt);
      end
   endtask

   task automatic test_single();
      int b0;
      int t0;
      b0 = beats;
      tready = 1'b1;
      exp_q.push_back(8'h55);
      t0 = cyc;
      send_byte(8'h55, 1'b1);
      wait_drain(30);
      n_vec++;
      if (beats - b0 != 1) begin
         n_err++;
         $display("FAIL single_count: got %0d beats, required 1", beats - b0);
      end
      // Stop centre is 9.5 bit times after the start edge, plus synchronizer delay.
      n_vec++;
      if (rise_cyc - t0 < 96 || rise_cyc - t0 > 100) begin
         n_err++;
         $display("FAIL single_latency: got %0d cycles, required 96..100", rise_cyc - t0);
      end
      n_vec++;
      if (last_run != 1) begin
         n_err++;
         $display("FAIL single_width: got valid for %0d cycles, required 1", last_run);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] msg [3];
      int b0;
      int l0;
      msg[0] = 8'h4F;
      msg[1] = 8'h4B;
      msg[2] = 8'h0A;
      b0 = beats;
      l0 = last_beats;
      tready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(msg[i]);
         send_byte(msg[i], 1'b1);
      end
      wait_drain(30);
      n_vec++;
      if (beats - b0 != 3 || last_beats - l0 != 1) begin
         n_err++;
         $display("FAIL b2b_count: got %0d beats %0d tlast, required 3 beats 1 tlast",
                  beats - b0, last_beats - l0);
      end
   endtask

   task automatic test_overrun();
      int b0;
      int o0;
      int exp_ovr;
      logic [7:0] b;
      b0 = beats;
      o0 = ovr_cnt;
      exp_ovr = 0;
      tready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         b = 8'($urandom_range(0, 255));
         if (exp_q.size() < DEPTH) exp_q.push_back(b);
         else exp_ovr++;
         send_byte(b, 1'b1);
      end
      tick(5);
      n_vec++;
      if (ovr_cnt - o0 != exp_ovr) begin
         n_err++;
         $display("FAIL overrun_pulses: got %0d, required %0d", ovr_cnt - o0, exp_ovr);
      end
      n_vec++;
      if (tvalid !== 1'b1 || tdata !== exp_q[0]) begin
         n_err++;
         $display("FAIL overrun_head: got valid=%b data=%h, required valid=1 data=%h",
                  tvalid, tdata, exp_q[0]);
      end
      tready = 1'b1;
      wait_drain(40);
      n_vec++;
      if (beats - b0 != DEPTH) begin
         n_err++;
         $display("FAIL overrun_kept: got %0d beats, required %0d", beats - b0, DEPTH);
      end
   endtask

   task automatic test_frame_err();
      int b0;
      int f0;
      b0 = beats;
      f0 = fe_cnt;
      tready = 1'b1;
      send_byte(8'h41, 1'b0);
      tick(30);
      uart_rx = 1'b1;
      tick(20);
      n_vec++;
      if (fe_cnt - f0 != 1 || beats - b0 != 0) begin
         n_err++;
         $display("FAIL frame_err: got %0d errors %0d beats, required 1 error 0 beats",
                  fe_cnt - f0, beats - b0);
      end
      exp_q.push_back(8'h42);
      send_byte(8'h42, 1'b1);
      wait_drain(30);
      n_vec++;
      if (beats - b0 != 1 || fe_cnt - f0 != 1) begin
         n_err++;
         $display("FAIL frame_recover: got %0d beats %0d errors, required 1 beat 1 error",
                  beats - b0, fe_cnt - f0);
      end
   endtask

   task automatic test_glitch();
      int b0;
      int f0;
      int o0;
      b0 = beats;
      f0 = fe_cnt;
      o0 = ovr_cnt;
      uart_rx = 1'b0;
      tick(3);
      uart_rx = 1'b1;
      tick(40);
      n_vec++;
      if (beats - b0 != 0 || fe_cnt - f0 != 0 || ovr_cnt - o0 != 0 || tvalid !== 1'b0) begin
         n_err++;
         $display("FAIL glitch: got beats=%0d ferr=%0d ovr=%0d valid=%b, required 0/0/0/0",
                  beats - b0, fe_cnt - f0, ovr_cnt - o0, tvalid);
      end
   endtask

   task automatic test_reset_mid_byte();
      logic [7:0] b;
      int b0;
      b = 8'h96;
      tready = 1'b0;
      exp_q.push_back(8'h3C);
      send_byte(8'h3C, 1'b1);
      uart_rx = 1'b0;
      tick(CPB);
      for (int i = 0; i < 4; i++) begin
         uart_rx = b[i];
         tick(CPB);
      end
      uart_rx = b[4];
      tick(3);
      rst_n = 1'b0;
      exp_q.delete();
      tick(2);
      check_reset_outputs("reset_mid_byte");
      uart_rx = 1'b1;
      tick(2);
      rst_n = 1'b1;
      tick(20);
      n_vec++;
      if (tvalid !== 1'b0) begin
         n_err++;
         $display("FAIL reset_flush: got valid=%b, required 0", tvalid);
      end
      b0 = beats;
      tready = 1'b1;
      exp_q.push_back(8'hA5);
      send_byte(8'hA5, 1'b1);
      wait_drain(30);
      n_vec++;
      if (beats - b0 != 1) begin
         n_err++;
         $display("FAIL reset_recover: got %0d beats, required 1", beats - b0);
      end
   endtask

   task automatic test_random();
      logic [7:0] b;
      int b0;
      int f0;
      int o0;
      b0 = beats;
      f0 = fe_cnt;
      o0 = ovr_cnt;
      rand_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         b = 8'($urandom_range(0, 255));
         exp_q.push_back(b);
         send_byte(b, 1'b1);
         tick($urandom_range(1, 30));
      end
      wait_drain(200);
      rand_ready = 1'b0;
      tick(1);
      tready = 1'b1;
      n_vec++;
      if (beats - b0 != 8 || fe_cnt - f0 != 0 || ovr_cnt - o0 != 0) begin
         n_err++;
         $display("FAIL random: got beats=%0d ferr=%0d ovr=%0d, required 8/0/0",
                  beats - b0, fe_cnt - f0, ovr_cnt - o0);
      end
   endtask

   // ---------------- sequence ----------------
   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_overrun();
      test_frame_err();
      test_glitch();
      test_reset_mid_byte();
      test_random();
      tick(5);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #1000000;
      n_err++;
      $display("FAIL watchdog: got simulation still running, required completion");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_uart_stream_rx
